// File: rtl/fetch_latch_unit.sv
// Fetch PC register plus the F/D and D/X pipeline latches, with stall, jump-squash
// and branch-squash control and a saturating count of inserted bubbles.
module fetch_latch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] PCnext,
  input  logic        stall,
  input  logic        flushJ,
  input  logic        flushB,
  input  logic [31:0] q_imem,
  output logic [11:0] address_imem,
  output logic [31:0] pc,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_ir,
  output logic        fd_valid,
  output logic [31:0] dx_pc,
  output logic [31:0] dx_ir,
  output logic        dx_valid,
  output logic [15:0] bubble_count
);

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_STALL  = 2'd1,
    MODE_FLUSHJ = 2'd2,
    MODE_FLUSHB = 2'd3
  } mode_e;

  mode_e       mode;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_pc_q, fd_pc_d, fd_ir_q, fd_ir_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] dx_pc_q, dx_pc_d, dx_ir_q, dx_ir_d;
  logic        dx_valid_q, dx_valid_d;
  logic [15:0] bubble_count_q, bubble_count_d;

  // A branch squash outranks a jump squash, which outranks a load-use stall.
  always_comb begin
    mode = MODE_RUN;
    if (flushB)      mode = MODE_FLUSHB;
    else if (flushJ) mode = MODE_FLUSHJ;
    else if (stall)  mode = MODE_STALL;
  end

  always_comb begin
    pc_d       = pc_q;
    fd_pc_d    = fd_pc_q;
    fd_ir_d    = fd_ir_q;
    fd_valid_d = fd_valid_q;
    dx_pc_d    = fd_pc_q;
    dx_ir_d    = fd_ir_q;
    dx_valid_d = fd_valid_q;
    case (mode)
      MODE_RUN: begin
        pc_d       = PCnext;
        fd_pc_d    = pc_q;
        fd_ir_d    = q_imem;
        fd_valid_d = 1'b1;
      end
      MODE_STALL: begin
        dx_ir_d    = NOP;
        dx_valid_d = 1'b0;
      end
      MODE_FLUSHJ: begin
        pc_d       = PCnext;
        fd_pc_d    = pc_q;
        fd_ir_d    = NOP;
        fd_valid_d = 1'b0;
      end
      default: begin
        pc_d       = PCnext;
        fd_pc_d    = pc_q;
        fd_ir_d    = NOP;
        fd_valid_d = 1'b0;
        dx_ir_d    = NOP;
        dx_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (mode != MODE_RUN && bubble_count_q != 16'hFFFF)
      bubble_count_d = bubble_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      fd_pc_q        <= 32'h0;
      fd_ir_q        <= NOP;
      fd_valid_q     <= 1'b0;
      dx_pc_q        <= 32'h0;
      dx_ir_q        <= NOP;
      dx_valid_q     <= 1'b0;
      bubble_count_q <= 16'h0;
    end else begin
      pc_q           <= pc_d;
      fd_pc_q        <= fd_pc_d;
      fd_ir_q        <= fd_ir_d;
      fd_valid_q     <= fd_valid_d;
      dx_pc_q        <= dx_pc_d;
      dx_ir_q        <= dx_ir_d;
      dx_valid_q     <= dx_valid_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign address_imem = pc_q[11:0];
  assign pc           = pc_q;
  assign fd_pc        = fd_pc_q;
  assign fd_ir        = fd_ir_q;
  assign fd_valid     = fd_valid_q;
  assign dx_pc        = dx_pc_q;
  assign dx_ir        = dx_ir_q;
  assign dx_valid     = dx_valid_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_fetch_latch_unit.sv
// Bench for fetch_latch_unit: directed vectors, a behavioural pipeline model checked
// every falling edge, and literal checks of the worked examples.
module tb_fetch_latch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PCnext = 32'h0;
  logic        stall = 1'b0, flushJ = 1'b0, flushB = 1'b0;
  logic [31:0] q_imem;
  logic [11:0] address_imem;
  logic [31:0] pc, fd_pc, fd_ir, dx_pc, dx_ir;
  logic        fd_valid, dx_valid;
  logic [15:0] bubble_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc = 32'h0, m_fd_pc = 32'h0, m_fd_ir = 32'h0, m_dx_pc = 32'h0, m_dx_ir = 32'h0;
  logic        m_fd_v = 1'b0, m_dx_v = 1'b0;
  logic [15:0] m_bc = 16'h0;

  fetch_latch_unit #(.RESET_PC(RST_PC), .NOP(NOP_W)) dut (
    .clock(clock), .reset(reset), .PCnext(PCnext), .stall(stall), .flushJ(flushJ),
    .flushB(flushB), .q_imem(q_imem), .address_imem(address_imem), .pc(pc),
    .fd_pc(fd_pc), .fd_ir(fd_ir), .fd_valid(fd_valid), .dx_pc(dx_pc), .dx_ir(dx_ir),
    .dx_valid(dx_valid), .bubble_count(bubble_count)
  );

  // Clock/reset block
  always #5 clock = ~clock;

  // Instruction memory: the word at address a is a + 0x100, keyed on the expected PC.
  assign q_imem = m_pc + 32'h100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what each stage holds after an edge, from the mode rules.
  always @(posedge clock) begin
    logic [31:0] o_pc, o_fd_pc, o_fd_ir;
    logic        o_fd_v, bubble;
    o_pc = m_pc; o_fd_pc = m_fd_pc; o_fd_ir = m_fd_ir; o_fd_v = m_fd_v;
    if (reset) begin
      m_pc = RST_PC; m_fd_pc = 0; m_fd_ir = NOP_W; m_fd_v = 0;
      m_dx_pc = 0; m_dx_ir = NOP_W; m_dx_v = 0; m_bc = 0;
    end else begin
      bubble = flushB | flushJ | stall;
      m_dx_pc = o_fd_pc;
      if (flushB || (!flushJ && stall)) begin
        m_dx_ir = NOP_W; m_dx_v = 0;
      end else begin
        m_dx_ir = o_fd_ir; m_dx_v = o_fd_v;
      end
      if (flushB || flushJ) begin
        m_pc = PCnext; m_fd_pc = o_pc; m_fd_ir = NOP_W; m_fd_v = 0;
      end else if (!stall) begin
        m_pc = PCnext; m_fd_pc = o_pc; m_fd_ir = o_pc + 32'h100; m_fd_v = 1;
      end
      if (bubble && m_bc != 16'hFFFF) m_bc = m_bc + 1;
    end
  end

  // Scoreboard compare on every falling edge
  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("address_imem", 32'(address_imem), 32'(m_pc[11:0]));
      chk("fd_pc", fd_pc, m_fd_pc);
      chk("fd_ir", fd_ir, m_fd_ir);
      chk("fd_valid", 32'(fd_valid), 32'(m_fd_v));
      chk("dx_pc", dx_pc, m_dx_pc);
      chk("dx_ir", dx_ir, m_dx_ir);
      chk("dx_valid", 32'(dx_valid), 32'(m_dx_v));
      chk("bubble_count", 32'(bubble_count), 32'(m_bc));
    end
  end

  // Driver: apply one vector, take one edge, return just after it.
  task automatic step(input logic rst, input logic st, input logic fj, input logic fb,
                      input logic inc, input logic [31:0] nxt);
    reset = rst; stall = st; flushJ = fj; flushB = fb;
    PCnext = inc ? m_pc + 32'h1 : nxt;
    @(posedge clock);
    #1;
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 32'h0);
    step(1, 1, 1, 1, 0, 32'h55);
    chk_en = 1'b1;
    chk("reset_pc", pc, RST_PC);
    chk("reset_fd_ir", fd_ir, NOP_W);
    chk("reset_fd_valid", 32'(fd_valid), 32'h0);
    chk("reset_bubble", 32'(bubble_count), 32'h0);

    // Three RUN edges, the first right after reset release
    step(0, 0, 0, 0, 1, 32'h0);
    chk("first_run_fd_valid", 32'(fd_valid), 32'h1);
    step(0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0);
    chk("run3_pc", pc, 32'h3);
    chk("run3_fd_ir", fd_ir, 32'h102);
    chk("run3_fd_pc", fd_pc, 32'h2);
    chk("run3_dx_ir", dx_ir, 32'h101);
    chk("run3_dx_pc", dx_pc, 32'h1);
    chk("run3_valids", {30'h0, fd_valid, dx_valid}, 32'h3);
    chk("run3_bubble", 32'(bubble_count), 32'h0);

    // Stall, then release
    step(0, 1, 0, 0, 0, 32'hDEAD);
    chk("stall_pc", pc, 32'h3);
    chk("stall_fd_ir", fd_ir, 32'h102);
    chk("stall_dx_ir", dx_ir, NOP_W);
    chk("stall_dx_valid", 32'(dx_valid), 32'h0);
    chk("stall_bubble", 32'(bubble_count), 32'h1);
    step(0, 0, 0, 0, 1, 32'h0);
    chk("unstall_dx_ir", dx_ir, 32'h102);

    // Jump squash (with stall also raised: the jump wins)
    step(0, 1, 1, 0, 0, 32'h40);
    chk("flushj_pc", pc, 32'h40);
    chk("flushj_fd_ir", fd_ir, NOP_W);
    chk("flushj_fd_valid", 32'(fd_valid), 32'h0);
    chk("flushj_dx_ir", dx_ir, 32'h103);
    chk("flushj_dx_valid", 32'(dx_valid), 32'h1);
    chk("flushj_bubble", 32'(bubble_count), 32'h2);
    step(0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0);

    // Branch squash with every other request raised
    step(0, 1, 1, 1, 0, 32'h80);
    chk("flushb_pc", pc, 32'h80);
    chk("flushb_valids", {30'h0, fd_valid, dx_valid}, 32'h0);
    chk("flushb_bubble", 32'(bubble_count), 32'h3);

    // PC wider than the instruction address
    step(0, 0, 0, 0, 0, 32'h0000_1005);
    chk("wide_pc", pc, 32'h0000_1005);
    chk("wide_addr", 32'(address_imem), 32'h005);
    step(0, 0, 0, 0, 0, 32'hFFFF_F7FE);
    chk("wide_pc2", pc, 32'hFFFF_F7FE);
    chk("wide_addr2", 32'(address_imem), 32'h7FE);

    // Mixed directed sequence
    step(0, 0, 1, 0, 0, 32'h200);
    step(0, 1, 0, 0, 0, 32'h300);
    step(0, 1, 0, 0, 0, 32'h300);
    step(0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 1, 0, 32'h10);
    step(0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 0, 1, 0, 32'h44);
    chk("midreset_pc", pc, RST_PC);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 32'h0);
    chk("rerun_pc", pc, 32'h6);
    chk("rerun_fd_ir", fd_ir, 32'h105);

    // Saturation
    for (int i = 0; i < 70000; i++) step(0, 1, 0, 0, 0, 32'h0);
    chk("sat_bubble", 32'(bubble_count), 32'hFFFF);
    step(0, 0, 1, 0, 0, 32'h20);
    chk("sat_hold", 32'(bubble_count), 32'hFFFF);
    step(1, 1, 0, 1, 0, 32'h99);
    chk("sat_reset_bubble", 32'(bubble_count), 32'h0);
    chk("sat_reset_pc", pc, RST_PC);
    chk("sat_reset_valids", {30'h0, fd_valid, dx_valid}, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0);

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_latch_unit.md
FETCH_LATCH_UNIT -- requirements
Module: fetch_latch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP, default 32'h0000_0000, instruction word used for every bubble and squash.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-005 PCnext  input  32  next-PC value from the next-PC logic.
REQ-006 stall  input  1  load-use hazard; hold PC and F/D, bubble D/X.
REQ-007 flushJ  input  1  jump/jr/bex taken in decode; squash the fetched word.
REQ-008 flushB  input  1  branch taken; squash both younger stages.
REQ-009 q_imem  input  32  instruction memory read data; combinational read of address_imem, valid in the same cycle.
REQ-010 address_imem  output  12  instruction memory word address.
REQ-011 pc  output  32  current fetch PC.
REQ-012 fd_pc, fd_ir  output  32 each  F/D latch PC and instruction.
REQ-013 fd_valid  output  1  F/D holds a real instruction.
REQ-014 dx_pc, dx_ir  output  32 each  D/X latch PC and instruction.
REQ-015 dx_valid  output  1  D/X holds a real instruction.
REQ-016 bubble_count  output  16  saturating count of cycles that inserted a bubble or squash.

Function
REQ-017 address_imem SHALL equal pc[11:0] combinationally.
REQ-018 Per rising edge with reset low, exactly one of four modes SHALL apply, priority flushB > flushJ > stall > RUN.
REQ-019 RUN: pc<=PCnext; fd_pc<=pc, fd_ir<=q_imem, fd_valid<=1; dx_pc<=fd_pc, dx_ir<=fd_ir, dx_valid<=fd_valid.
REQ-020 STALL: pc and all F/D fields SHALL hold; dx_ir<=NOP, dx_pc<=fd_pc, dx_valid<=0.
REQ-021 FLUSHJ: pc<=PCnext; fd_ir<=NOP, fd_pc<=pc, fd_valid<=0; D/X SHALL advance from F/D as in RUN (the jump itself proceeds).
REQ-022 FLUSHB: pc<=PCnext; fd_ir<=NOP, fd_valid<=0, fd_pc<=pc; dx_ir<=NOP, dx_valid<=0, dx_pc<=fd_pc; stall and flushJ ignored that cycle.
REQ-023 Simultaneous stall with flushJ or flushB SHALL resolve per REQ-018; the stalled instruction is discarded, not held.
REQ-024 bubble_count SHALL increment by 1 on every edge in STALL, FLUSHJ or FLUSHB mode, and hold in RUN.
REQ-025 bubble_count SHALL saturate at 16'hFFFF and never wrap.
REQ-026 pc SHALL be a full 32-bit register; PCnext wrapping beyond 12 bits SHALL only affect address_imem by truncation.
REQ-027 No output other than address_imem SHALL change except on a rising clock edge.

Reset
REQ-028 On a rising edge with reset high: pc<=RESET_PC; fd_ir, dx_ir<=NOP; fd_pc, dx_pc<=0; fd_valid, dx_valid<=0; bubble_count<=0.
REQ-029 reset SHALL override every mode including flushB, stall and a saturated counter.
REQ-030 First edge after reset release SHALL operate in the mode selected by the inputs (no extra idle cycle).

Verification
REQ-031 Reset, then 3 RUN edges with PCnext=pc+1, q_imem=pc+32'h100 -> pc=3, fd_ir=32'h102, fd_pc=2, dx_ir=32'h101, dx_pc=1, both valid, bubble_count=0.
REQ-032 From REQ-031 state, one stall edge -> pc=3, fd_ir=32'h102 held, dx_ir=NOP, dx_valid=0, bubble_count=1; next RUN edge -> dx_ir=32'h102.
REQ-033 flushJ with PCnext=32'h40 -> pc=32'h40, fd_ir=NOP, fd_valid=0, dx_ir=previous fd_ir, dx_valid=1.
REQ-034 flushB, flushJ and stall asserted together, PCnext=32'h80 -> pc=32'h80, fd_valid=0, dx_valid=0, bubble_count+1.
REQ-035 Hold stall for 70000 cycles -> bubble_count=16'hFFFF and stays; reset edge -> bubble_count=0, pc=RESET_PC, all valids 0.
REQ-036 PCnext=32'h0000_1005 on RUN -> pc=32'h0000_1005, address_imem=12'h005.
